evg_event_arbiter: RTL and testbench
====================================

EVG_EVENT_ARBITER -- requirements
Module: evg_event_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQUESTERS, default 4: number of event request sources, legal range 2..8.
REQ-002 The block SHALL have parameter EVENTCODE_WIDTH, default 8: width of event codes.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4: entries per requester queue, a power of two >= 2.
REQ-004 The block SHALL have port evgTxClk, input, 1 bit: the single clock; all logic is in this domain.
REQ-005 The block SHALL have port evgTxRst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port reqTDATA, input, NUM_REQUESTERS*EVENTCODE_WIDTH bits: event code of requester i in slice i.
REQ-007 The block SHALL have port reqTVALID, input, NUM_REQUESTERS bits: single-cycle request strobe per requester, with no backpressure.
REQ-008 The block SHALL have port reqEnable, input, NUM_REQUESTERS bits: per-requester enable, quasi-static.
REQ-009 The block SHALL have port overflowClear, input, 1 bit: single-cycle pulse that clears the overflow flags.
REQ-010 The block SHALL have port evgEventTDATA, output, EVENTCODE_WIDTH bits: granted event code.
REQ-011 The block SHALL have port evgEventTVALID, output, 1 bit: granted event valid.
REQ-012 The block SHALL have port evgEventTREADY, input, 1 bit: the transmitter accepts the event this cycle.
REQ-013 The block SHALL have port overflow, output, NUM_REQUESTERS bits: sticky per-requester drop flags.
REQ-014 The block SHALL have port pending, output, NUM_REQUESTERS bits: per-requester queue-non-empty indication.

Function
REQ-015 Each requester SHALL own a FIFO_DEPTH-entry FIFO; a request with reqTVALID[i]=1 and reqEnable[i]=1 is written at that clock edge.
REQ-016 A request whose code is 0 (null event) SHALL be discarded: not queued and not flagged.
REQ-017 A request to a full FIFO SHALL be dropped and overflow[i] set; if a pop from that FIFO occurs at the same edge, the write SHALL be accepted instead.
REQ-018 overflowClear SHALL clear all overflow bits; a new overflow at the same edge SHALL take precedence and leave that bit set.
REQ-019 When reqEnable[i] is low, FIFO i SHALL be flushed: pointers reset, pending[i]=0, and incoming requests ignored without setting overflow.
REQ-020 The output register SHALL load when evgEventTVALID=0 or evgEventTREADY=1, and SHALL otherwise hold TDATA and TVALID stable.
REQ-021 On load, the arbiter SHALL grant the lowest-index non-empty FIFO (fixed priority, index 0 highest), pop one entry from it, and set TVALID=1.
REQ-022 On load with all FIFOs empty, TVALID SHALL go to 0 and TDATA SHALL hold its previous value.
REQ-023 Latency SHALL be as follows: a request strobed in cycle n with idle output and empty queues appears with TVALID=1 in cycle n+2.
REQ-024 With TREADY held high, the block SHALL sustain one event per cycle.
REQ-025 A FIFO SHALL never be popped and granted twice for the same entry; pointer wrap SHALL use an extra MSB to distinguish full from empty.
REQ-026 The pending output SHALL reflect the registered FIFO state, which is the state after the current edge.

Reset
REQ-027 On evgTxRst high, all FIFOs SHALL empty immediately.
REQ-028 On evgTxRst high, evgEventTVALID, overflow and pending SHALL be driven to 0 and evgEventTDATA to 0.
REQ-029 A reset mid-handshake SHALL drop the held event without reissuing it.
REQ-030 The first load SHALL be permitted on the first clock edge after evgTxRst deasserts.

Structure
REQ-031 The shared package evg_pkg SHALL hold EVENTCODE_WIDTH default, NULL_EVENT_CODE (0) and END_OF_TABLE_EVENT_CODE (0x7F).
REQ-032 The per-requester queue SHALL be a sub-module, evg_event_fifo, instantiated NUM_REQUESTERS times.
REQ-033 Arbitration and the output register SHALL reside in the top module.

Verification
REQ-034 A bench SHALL drive a single request on requester 2 with code 0x15 in cycle 10, TREADY=1, and check that TDATA=0x15 with TVALID=1 in cycle 12 only.
REQ-035 A bench SHALL strobe all four requesters in the same cycle with codes 0x01..0x04, TREADY=1, and check the output order 0x01,0x02,0x03,0x04 on consecutive cycles.
REQ-036 A bench SHALL send 6 requests to requester 0 on consecutive cycles with TREADY=0, and check that 4 are queued, the first is held in the output register, overflow[0]=1, and after TREADY=1 exactly 5 events emerge in order.
REQ-037 A bench SHALL hold TREADY low for 3 cycles while TVALID=1 with TDATA=0x22, and check that TDATA stays stable and a higher-priority request arriving meanwhile is emitted only after 0x22.
REQ-038 A bench SHALL issue code 0x00 and requests while reqEnable[1]=0, and check that there is no output, overflow stays 0 and pending[1]=0.
REQ-039 A bench SHALL assert evgTxRst for 1 cycle with 3 events queued and TVALID=1, and check that all outputs are 0 and no queued event emerges afterwards.

Source files
------------

// File: rtl/evg_pkg.sv
// Shared event-generator definitions: default code width and reserved event codes.
package evg_pkg;

    localparam int EVG_EVENTCODE_WIDTH = 8;

    localparam logic [EVG_EVENTCODE_WIDTH-1:0] NULL_EVENT_CODE         = 8'h00;
    localparam logic [EVG_EVENTCODE_WIDTH-1:0] END_OF_TABLE_EVENT_CODE = 8'h7F;

endpackage

// File: rtl/evg_event_fifo.sv
// Per-requester event queue with first-word-fall-through read and a drop strobe
// for writes that find the queue full without a concurrent pop.
module evg_event_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              empty_o,
    output logic              drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              full;
    logic              do_rd;
    logic              do_wr;

    // The extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd     = rd_en_i && !empty_o && !flush_i;
    assign do_wr     = wr_en_i && !flush_i && (!full || do_rd);
    assign drop_o    = wr_en_i && !flush_i && full && !do_rd;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/evg_event_arbiter.sv
// Fixed-priority arbiter merging per-requester event queues into one registered
// AXI-stream-like event output; index 0 has the highest priority.
module evg_event_arbiter
    import evg_pkg::*;
#(
    parameter int NUM_REQUESTERS  = 4,
    parameter int EVENTCODE_WIDTH = EVG_EVENTCODE_WIDTH,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                      evgTxClk,
    input  logic                                      evgTxRst,
    input  logic [NUM_REQUESTERS*EVENTCODE_WIDTH-1:0] reqTDATA,
    input  logic [NUM_REQUESTERS-1:0]                 reqTVALID,
    input  logic [NUM_REQUESTERS-1:0]                 reqEnable,
    input  logic                                      overflowClear,
    output logic [EVENTCODE_WIDTH-1:0]                evgEventTDATA,
    output logic                                      evgEventTVALID,
    input  logic                                      evgEventTREADY,
    output logic [NUM_REQUESTERS-1:0]                 overflow,
    output logic [NUM_REQUESTERS-1:0]                 pending
);

    localparam logic [EVENTCODE_WIDTH-1:0] NULL_CODE = EVENTCODE_WIDTH'(NULL_EVENT_CODE);

    logic [NUM_REQUESTERS-1:0]                      wr_en;
    logic [NUM_REQUESTERS-1:0]                      pop;
    logic [NUM_REQUESTERS-1:0]                      drop;
    logic [NUM_REQUESTERS-1:0]                      fifo_empty;
    logic [NUM_REQUESTERS-1:0][EVENTCODE_WIDTH-1:0] fifo_data;
    logic [NUM_REQUESTERS-1:0]                      avail;
    logic [NUM_REQUESTERS-1:0]                      grant_oh;
    logic [EVENTCODE_WIDTH-1:0]                     grant_data;
    logic                                           load;

    logic [EVENTCODE_WIDTH-1:0] tdata_q, tdata_d;
    logic                       tvalid_q, tvalid_d;
    logic [NUM_REQUESTERS-1:0]  overflow_q, overflow_d;

    for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_req
        assign wr_en[i] = reqTVALID[i] && reqEnable[i] &&
                          (reqTDATA[i*EVENTCODE_WIDTH +: EVENTCODE_WIDTH] != NULL_CODE);

        evg_event_fifo #(
            .DATA_W (EVENTCODE_WIDTH),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk_i     (evgTxClk),
            .rst_i     (evgTxRst),
            .flush_i   (~reqEnable[i]),
            .wr_en_i   (wr_en[i]),
            .wr_data_i (reqTDATA[i*EVENTCODE_WIDTH +: EVENTCODE_WIDTH]),
            .rd_en_i   (pop[i]),
            .rd_data_o (fifo_data[i]),
            .empty_o   (fifo_empty[i]),
            .drop_o    (drop[i])
        );
    end

    // A queue being flushed this cycle is not eligible for a grant.
    assign avail    = ~fifo_empty & reqEnable;
    assign grant_oh = avail & (~avail + 1'b1);
    assign load     = !tvalid_q || evgEventTREADY;
    assign pop      = load ? grant_oh : '0;

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (grant_oh[i]) grant_data = grant_data | fifo_data[i];
        end
    end

    always_comb begin
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        overflow_d = (overflowClear ? '0 : overflow_q) | drop;
        if (load) begin
            tvalid_d = |grant_oh;
            if (|grant_oh) tdata_d = grant_data;
        end
    end

    always_ff @(posedge evgTxClk or posedge evgTxRst) begin
        if (evgTxRst) begin
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            overflow_q <= '0;
        end else begin
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            overflow_q <= overflow_d;
        end
    end

    assign evgEventTDATA  = tdata_q;
    assign evgEventTVALID = tvalid_q;
    assign overflow       = overflow_q;
    assign pending        = ~fifo_empty;

endmodule

// File: tb/tb_evg_event_arbiter.sv
// Directed bench for evg_event_arbiter: latency, priority order, overflow,
// output hold under backpressure, disabled requesters and mid-handshake reset.
module tb_evg_event_arbiter;

    localparam int NR = 4;
    localparam int CW = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR*CW-1:0] reqTDATA = '0;
    logic [NR-1:0]    reqTVALID = '0;
    logic [NR-1:0]    reqEnable = '1;
    logic             overflowClear = 1'b0;
    logic [CW-1:0]    evgEventTDATA;
    logic             evgEventTVALID;
    logic             evgEventTREADY = 1'b1;
    logic [NR-1:0]    overflow;
    logic [NR-1:0]    pending;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    evg_event_arbiter #(
        .NUM_REQUESTERS  (NR),
        .EVENTCODE_WIDTH (CW),
        .FIFO_DEPTH      (4)
    ) dut (
        .evgTxClk       (clk),
        .evgTxRst       (rst),
        .reqTDATA       (reqTDATA),
        .reqTVALID      (reqTVALID),
        .reqEnable      (reqEnable),
        .overflowClear  (overflowClear),
        .evgEventTDATA  (evgEventTDATA),
        .evgEventTVALID (evgEventTVALID),
        .evgEventTREADY (evgEventTREADY),
        .overflow       (overflow),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic out_chk(input string tag, input logic v, input logic [7:0] d);
        check({tag, ".vld"}, 32'(evgEventTVALID), 32'(v));
        if (v) check({tag, ".data"}, 32'(evgEventTDATA), 32'(d));
    endtask

    task automatic idle(input int n);
        reqTVALID = '0;
        reqTDATA  = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        step();
        check("rst.vld",  32'(evgEventTVALID), 32'h0);
        check("rst.data", 32'(evgEventTDATA),  32'h0);
        check("rst.ovf",  32'(overflow),       32'h0);
        check("rst.pend", 32'(pending),        32'h0);
        rst = 1'b0;
        cyc = 0;

        // Single request on requester 2 in cycle 10: visible in cycle 12 only.
        while (cyc < 10) step();
        reqTDATA  = 32'h0015_0000;
        reqTVALID = 4'b0100;
        out_chk("lat.c10", 1'b0, 8'h00);
        step();
        reqTVALID = '0;
        reqTDATA  = '0;
        out_chk("lat.c11", 1'b0, 8'h00);
        check("lat.pend11", 32'(pending), 32'h4);
        step();
        out_chk("lat.c12", 1'b1, 8'h15);
        check("lat.pend12", 32'(pending), 32'h0);
        step();
        out_chk("lat.c13", 1'b0, 8'h00);
        check("lat.hold", 32'(evgEventTDATA), 32'h15);
        idle(2);

        // All four requesters at once: priority order, one per cycle.
        reqTDATA  = 32'h0403_0201;
        reqTVALID = 4'b1111;
        step();
        reqTVALID = '0;
        check("prio.pend", 32'(pending), 32'hF);
        for (int k = 1; k <= 4; k++) begin
            step();
            out_chk("prio.seq", 1'b1, 8'(k));
        end
        step();
        out_chk("prio.end", 1'b0, 8'h00);
        idle(2);

        // Six requests to requester 0 with TREADY low: one held, four queued, one dropped.
        evgEventTREADY = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            reqTDATA  = 32'(8'h30 + 8'(k));
            reqTVALID = 4'b0001;
            step();
        end
        reqTVALID = '0;
        reqTDATA  = '0;
        check("ovf.flag", 32'(overflow), 32'h1);
        check("ovf.pend", 32'(pending),  32'h1);
        out_chk("ovf.held", 1'b1, 8'h31);
        evgEventTREADY = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            step();
            out_chk("ovf.drain", 1'b1, 8'h30 + 8'(k));
        end
        step();
        out_chk("ovf.end", 1'b0, 8'h00);
        check("ovf.sticky", 32'(overflow), 32'h1);
        overflowClear = 1'b1;
        step();
        overflowClear = 1'b0;
        check("ovf.clr", 32'(overflow), 32'h0);
        idle(2);

        // Backpressure: 0x22 held stable, later higher-priority request follows it.
        evgEventTREADY = 1'b0;
        reqTDATA  = 32'h2200_0000;
        reqTVALID = 4'b1000;
        step();
        reqTVALID = '0;
        step();
        out_chk("bp.first", 1'b1, 8'h22);
        reqTDATA  = 32'h0000_0005;
        reqTVALID = 4'b0001;
        step();
        reqTVALID = '0;
        out_chk("bp.hold1", 1'b1, 8'h22);
        step();
        out_chk("bp.hold2", 1'b1, 8'h22);
        evgEventTREADY = 1'b1;
        step();
        out_chk("bp.next", 1'b1, 8'h05);
        step();
        out_chk("bp.end", 1'b0, 8'h00);
        idle(2);

        // Null code and requests to a disabled requester are ignored.
        reqEnable = 4'b1101;
        step();
        for (int k = 0; k < 6; k++) begin
            reqTDATA  = 32'h0000_4400;
            reqTVALID = 4'b0110;
            step();
            check("dis.vld", 32'(evgEventTVALID), 32'h0);
        end
        idle(2);
        check("dis.ovf",  32'(overflow), 32'h0);
        check("dis.pend", 32'(pending),  32'h0);
        reqEnable = 4'b1111;
        step();
        check("dis.after", 32'(evgEventTVALID), 32'h0);
        idle(1);

        // Reset with three queued and one held: everything cleared, nothing reissued.
        evgEventTREADY = 1'b0;
        reqTDATA  = 32'h6463_6261;
        reqTVALID = 4'b1111;
        step();
        reqTVALID = '0;
        step();
        out_chk("rr.held", 1'b1, 8'h61);
        check("rr.pend", 32'(pending), 32'hE);
        rst = 1'b1;
        #1;
        check("rr.vld",  32'(evgEventTVALID), 32'h0);
        check("rr.data", 32'(evgEventTDATA),  32'h0);
        check("rr.pend0", 32'(pending),       32'h0);
        check("rr.ovf",  32'(overflow),       32'h0);
        step();
        rst = 1'b0;
        evgEventTREADY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr.quiet", 32'({evgEventTVALID, pending}), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
